// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants used by decoder, ALU and sequencer,
// plus the sequencer state encoding and opcode classification helpers.
package cpu_pkg;

    localparam logic [3:0] OP_RETI  = 4'b0001;
    localparam logic [3:0] OP_COPY  = 4'b1100;
    localparam logic [3:0] OP_WRITE = 4'b1101;
    localparam logic [3:0] OP_READ  = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_FETCH_W = 4'd1,
        ST_REGS    = 4'd2,
        ST_MEM     = 4'd3,
        ST_MEM_W   = 4'd4,
        ST_WB      = 4'd5,
        ST_WB_W    = 4'd6,
        ST_INT     = 4'd7,
        ST_HALT    = 4'd8
    } seq_state_e;

    function automatic logic op_reads_mem(input logic [3:0] op);
        return (op == OP_READ) || (op == OP_COPY);
    endfunction

    function automatic logic op_writes_mem(input logic [3:0] op);
        return (op == OP_WRITE) || (op == OP_COPY);
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder for interrupt requests: the lowest asserted index wins.
module int_prio_enc #(
    parameter int CH = 8
) (
    input  logic [CH-1:0] req_i,
    output logic [3:0]    idx_o,
    output logic          valid_o
);

    // Scan from the top so the lowest-index request is the last one written.
    always_comb begin
        idx_o   = 4'd0;
        valid_o = |req_i;
        for (int i = CH - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? 4'(i) : idx_o;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/REGS/MEM/WB phases with memory
// wait states, single-level interrupt entry and an optional HALT park state.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int INT_CH     = 8,
    parameter int CNT_W      = 32,
    parameter bit HALT_STALL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        instr_op,
    output logic              fetch,
    output logic              get_regs,
    output logic              read_mem,
    output logic              write_back,
    output logic              mem_start,
    input  logic              mem_busy,
    input  logic [INT_CH-1:0] int_req,
    output logic              int_take,
    output logic [7:0]        int_id,
    output logic              in_int,
    output logic              halted,
    output logic              instr_done,
    output logic [CNT_W-1:0]  retired
);

    seq_state_e        state_q;
    logic              in_int_q;
    logic [7:0]        int_id_q;
    logic [CNT_W-1:0]  retired_q;
    logic [3:0]        irq_idx_s;
    logic              irq_valid_s;
    logic              wb_done_s;
    logic              in_int_after_s;

    int_prio_enc #(.CH(INT_CH)) u_prio (
        .req_i   (int_req),
        .idx_o   (irq_idx_s),
        .valid_o (irq_valid_s)
    );

    // WB completes in one cycle without a write, else on the first idle memory cycle.
    always_comb begin
        wb_done_s      = ((state_q == ST_WB) && !op_writes_mem(instr_op)) ||
                         ((state_q == ST_WB_W) && !mem_busy);
        in_int_after_s = in_int_q && (instr_op != OP_RETI);
    end

    // Sequencer state, interrupt context and retirement counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            in_int_q  <= 1'b0;
            int_id_q  <= 8'd0;
            retired_q <= '0;
        end else begin
            case (state_q)
                ST_FETCH:   state_q <= ST_FETCH_W;
                ST_FETCH_W: if (!mem_busy) state_q <= ST_REGS;
                ST_REGS:    state_q <= ST_MEM;
                ST_MEM:     state_q <= op_reads_mem(instr_op) ? ST_MEM_W : ST_WB;
                ST_MEM_W:   if (!mem_busy) state_q <= ST_WB;
                ST_WB, ST_WB_W: begin
                    if (wb_done_s) begin
                        retired_q <= retired_q + CNT_W'(1);
                        in_int_q  <= in_int_after_s;
                        if (!in_int_after_s && irq_valid_s) begin
                            state_q <= ST_INT;
                        end else if (HALT_STALL && (instr_op == OP_HALT)) begin
                            state_q <= ST_HALT;
                        end else begin
                            state_q <= ST_FETCH;
                        end
                    end else begin
                        state_q <= ST_WB_W;
                    end
                end
                ST_INT: begin
                    int_id_q <= {4'd0, irq_idx_s};
                    in_int_q <= 1'b1;
                    state_q  <= ST_FETCH;
                end
                ST_HALT:    if (!in_int_q && irq_valid_s) state_q <= ST_INT;
                default:    state_q <= ST_FETCH;
            endcase
        end
    end

    // Phase strobes decode the registered state; gating with reset keeps them
    // quiet while reset is held yet lets FETCH show on the first free cycle.
    always_comb begin
        fetch      = 1'b0;
        get_regs   = 1'b0;
        read_mem   = 1'b0;
        write_back = 1'b0;
        mem_start  = 1'b0;
        int_take   = 1'b0;
        halted     = 1'b0;
        instr_done = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    fetch     = 1'b1;
                    mem_start = 1'b1;
                end
                ST_FETCH_W: fetch = 1'b1;
                ST_REGS:    get_regs = 1'b1;
                ST_MEM: begin
                    read_mem  = 1'b1;
                    mem_start = op_reads_mem(instr_op);
                end
                ST_MEM_W:   read_mem = 1'b1;
                ST_WB: begin
                    write_back = 1'b1;
                    mem_start  = op_writes_mem(instr_op);
                end
                ST_WB_W:    write_back = 1'b1;
                ST_INT:     int_take = 1'b1;
                ST_HALT:    halted = 1'b1;
                default:    fetch = 1'b0;
            endcase
            instr_done = wb_done_s;
        end else begin
            instr_done = 1'b0;
        end
    end

    assign in_int  = in_int_q;
    assign int_id  = int_id_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction expectations are
// queued at issue and compared when instr_done fires.
module tb_control_sequencer;

    localparam logic [3:0] T_ARITH = 4'b0010;
    localparam logic [3:0] T_RETI  = 4'b0001;
    localparam logic [3:0] T_COPY  = 4'b1100;
    localparam logic [3:0] T_WRITE = 4'b1101;
    localparam logic [3:0] T_READ  = 4'b1110;
    localparam logic [3:0] T_HALT  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  instr_op = 4'd0;
    logic        mem_busy = 1'b0;
    logic [7:0]  int_req = 8'd0;
    logic        fetch, get_regs, read_mem, write_back, mem_start;
    logic        int_take, in_int, halted, instr_done;
    logic [7:0]  int_id;
    logic [31:0] retired;

    logic        rst4 = 1'b1;
    logic [3:0]  op4 = 4'b0010;
    logic        busy4 = 1'b0;
    logic [7:0]  req4 = 8'd0;
    logic        f4, g4, r4, w4, ms4, take4, inint4, halt4, done4;
    logic [7:0]  id4;
    logic [3:0]  retired4;

    always #5 clk = ~clk;

    control_sequencer u_dut (
        .clk(clk), .reset(reset), .instr_op(instr_op),
        .fetch(fetch), .get_regs(get_regs), .read_mem(read_mem), .write_back(write_back),
        .mem_start(mem_start), .mem_busy(mem_busy), .int_req(int_req),
        .int_take(int_take), .int_id(int_id), .in_int(in_int), .halted(halted),
        .instr_done(instr_done), .retired(retired)
    );

    control_sequencer #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(rst4), .instr_op(op4),
        .fetch(f4), .get_regs(g4), .read_mem(r4), .write_back(w4),
        .mem_start(ms4), .mem_busy(busy4), .int_req(req4),
        .int_take(take4), .int_id(id4), .in_int(inint4), .halted(halt4),
        .instr_done(done4), .retired(retired4)
    );

    typedef struct {
        int          cycles;
        int          mstarts;
        int          fspan;
        int          wbspan;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] ret_model = 32'd0;

    // memory responder and per-instruction observation state
    int   fb_len = 0, mb_len = 0, wb_len = 0;
    int   pend_len = 0, busy_left = 0;
    bit   start_seen = 1'b0;
    int   cyc_cnt = 0, ms_cnt = 0, f_cnt = 0, wb_cnt = 0;
    bit   done_seen = 1'b0;
    logic s_fetch = 1'b0, s_mstart = 1'b0, s_read = 1'b0, s_take = 1'b0, s_halted = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        s_fetch  = fetch;
        s_mstart = mem_start;
        s_read   = read_mem;
        s_take   = int_take;
        s_halted = halted;
        check_eq("onehot", 64'($countones({fetch, get_regs, read_mem, write_back}) <= 1), 64'd1);
        if (mem_start) begin
            ms_cnt++;
            start_seen = 1'b1;
            pend_len   = fetch ? fb_len : (read_mem ? mb_len : wb_len);
        end
        if (fetch) f_cnt++;
        if (write_back) wb_cnt++;
        if (instr_done) done_seen = 1'b1;
        cyc_cnt++;
        @(posedge clk);
        #1;
        if (start_seen) begin
            busy_left  = pend_len;
            start_seen = 1'b0;
        end
        if (busy_left > 0) begin
            mem_busy = 1'b1;
            busy_left--;
        end else begin
            mem_busy = 1'b0;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        @(posedge clk);
        #1;
        busy_left = 0; start_seen = 1'b0; mem_busy = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("rst_zero", {fetch, get_regs, read_mem, write_back, mem_start, int_take,
                                  int_id, in_int, halted, instr_done, retired}, 64'd0);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Issue one instruction; busy lengths are cycles mem_busy stays high after each start.
    task automatic run_instr(input logic [3:0] op, input int fb, input int mb, input int wb);
        exp_t e;
        bit   rd, wr;
        instr_op = op; fb_len = fb; mb_len = mb; wb_len = wb;
        rd = (op == T_READ) || (op == T_COPY);
        wr = (op == T_WRITE) || (op == T_COPY);
        ret_model = ret_model + 32'd1;
        e.cycles  = 4 + (fb + 1) + (rd ? mb + 1 : 0) + (wr ? wb + 1 : 0);
        e.mstarts = 1 + int'(rd) + int'(wr);
        e.fspan   = fb + 2;
        e.wbspan  = 1 + (wr ? wb + 1 : 0);
        e.ret     = ret_model;
        sb_q.push_back(e);
        cyc_cnt = 0; ms_cnt = 0; f_cnt = 0; wb_cnt = 0; done_seen = 1'b0;
        cycle();
        check_eq("first_fetch", {s_fetch, s_mstart}, 64'd3);
        while (!done_seen && cyc_cnt < 60) cycle();
        if (!done_seen) check_eq("done_timeout", 64'd0, 64'd1);
        e = sb_q.pop_front();
        check_eq("cycles", cyc_cnt, e.cycles);
        check_eq("mem_starts", ms_cnt, e.mstarts);
        check_eq("fetch_span", f_cnt, e.fspan);
        check_eq("wb_span", wb_cnt, e.wbspan);
        check_eq("retired", retired, e.ret);
    endtask

    task automatic expect_int(input logic [7:0] id);
        cycle();
        check_eq("int_take", s_take, 64'd1);
        check_eq("int_id", int_id, id);
        check_eq("in_int_set", in_int, 64'd1);
    endtask

    initial begin
        int          n;
        int          n4;
        logic        d4;
        logic [31:0] ret_hold;

        do_reset(2);

        // reset while a READ sits in its memory wait state
        instr_op = T_READ; fb_len = 0; mb_len = 4; wb_len = 0;
        n = 0;
        s_read = 1'b0; s_mstart = 1'b0;
        while (!(s_read && s_mstart) && n < 20) begin
            cycle();
            n++;
        end
        check_eq("reach_mem", {s_read, s_mstart}, 64'd3);
        do_reset(2);

        run_instr(T_ARITH, 1, 0, 0);
        run_instr(T_COPY, 0, 0, 0);
        run_instr(T_COPY, 2, 1, 2);
        run_instr(T_READ, 0, 1, 0);
        run_instr(T_WRITE, 1, 0, 3);

        int_req = 8'b0010_0100;
        run_instr(T_ARITH, 0, 0, 0);
        expect_int(8'd2);
        int_req = 8'b0010_0000;
        run_instr(T_ARITH, 0, 0, 0);
        run_instr(T_RETI, 0, 0, 0);
        expect_int(8'd5);
        int_req = 8'd0;
        run_instr(T_RETI, 0, 0, 0);
        check_eq("in_int_clr", in_int, 64'd0);

        run_instr(T_HALT, 0, 0, 0);
        ret_hold = retired;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_eq("halted", s_halted, 64'd1);
        end
        check_eq("halt_retired", retired, ret_hold);
        int_req = 8'b0000_0001;
        cycle();
        expect_int(8'd0);
        check_eq("halt_exit", halted, 64'd0);
        int_req = 8'd0;
        run_instr(T_RETI, 0, 0, 0);
        check_eq("in_int_clr2", in_int, 64'd0);

        // narrow counter wraps after 16 retirements
        rst4 = 1'b0;
        n4 = 0;
        for (int c = 0; c < 300 && n4 < 17; c++) begin
            @(negedge clk);
            d4 = done4;
            @(posedge clk);
            #1;
            if (d4) begin
                n4++;
                check_eq("wrap4", retired4, 64'(n4 % 16));
            end
        end
        check_eq("wrap4_count", n4, 64'd17);
        check_eq("wrap4_final", retired4, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
